// File: rtl/sseg_pkg.sv
// Shared types, constants and the hex segment table for the seven-segment driver.
package sseg_pkg;

   // Segment vector, active-high: bit 0 = a ... bit 6 = g
   typedef logic [6:0] seg_t;

   // Decode mode selected by hex_en
   typedef enum logic {
      DEC_BCD = 1'b0,
      DEC_HEX = 1'b1
   } dec_mode_t;

   localparam seg_t SEG_BLANK = 7'h00;
   localparam seg_t SEG_DASH  = 7'h40;

   localparam seg_t HEX_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic seg_t hex_seg(input logic [3:0] nib);
      return HEX_TABLE[nib];
   endfunction

endpackage

// File: rtl/sseg_mux_driver_if.sv
// Bus between user logic and the display driver: load side plus display pins.
interface sseg_mux_driver_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic                load;
   logic                hex_en;
   logic                lz_blank;
   logic [DIGITS-1:0]   dp_mask;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame_done;

   modport master (
      output value, load, hex_en, lz_blank, dp_mask,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  value, load, hex_en, lz_blank, dp_mask,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/sseg_encoder.sv
// Combinational nibble to active-high segment decoder, hex or BCD.
module sseg_encoder
   import sseg_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_hex_en,
   output seg_t       o_seg
);

   // Table lookup; in BCD mode A-F collapse to a dash
   always_comb begin
      o_seg = hex_seg(i_nibble);
      if (dec_mode_t'(i_hex_en) == DEC_BCD && i_nibble > 4'd9) begin
         o_seg = SEG_DASH;
      end
   end

endmodule

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment driver: shadow register, prescaler,
// digit scan, leading-zero blanking and registered pin outputs.
module sseg_mux_driver
   import sseg_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int PRESCALE   = 100_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   sseg_mux_driver_if.slave   bus
);

   localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]       r_pre;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_val;
   logic                r_hex;
   logic                r_lz;
   logic [DIGITS-1:0]   r_dpm;
   logic [6:0]          r_seg;
   logic                r_dp;
   logic [DIGITS-1:0]   r_an;
   logic                r_frame;

   logic                w_tick;
   logic                w_last;
   logic [DIGITS-1:0]   w_lead_zero;
   logic [3:0]          w_nib;
   seg_t                w_seg_raw;
   seg_t                w_seg_hi;
   logic [DIGITS-1:0]   w_an_hi;

   assign w_tick = (r_pre == PW'(PRESCALE - 1));
   assign w_last = (r_idx == IW'(DIGITS - 1));

   // Prescaler and digit index; index steps on each terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre   <= '0;
         r_idx   <= '0;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_tick & w_last;
         if (w_tick) begin
            r_pre <= '0;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

   // Shadow register captured on the load strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_val <= '0;
         r_hex <= 1'b1;
         r_lz  <= 1'b0;
         r_dpm <= '0;
      end else if (bus.load) begin
         r_val <= bus.value;
         r_hex <= bus.hex_en;
         r_lz  <= bus.lz_blank;
         r_dpm <= bus.dp_mask;
      end
   end

   // Leading-zero map: digit i blanks when it and every digit above it are zero
   always_comb begin
      logic w_run;
      int unsigned i;
      w_run       = 1'b1;
      w_lead_zero = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         i = DIGITS - 1 - k;
         w_run = w_run & (r_val[4*i +: 4] == 4'h0);
         w_lead_zero[i] = w_run & r_lz & (i != 0);
      end
   end

   assign w_nib = r_val[{r_idx, 2'b00} +: 4];

   sseg_encoder u_enc (
      .i_nibble (w_nib),
      .i_hex_en (r_hex),
      .o_seg    (w_seg_raw)
   );

   assign w_seg_hi = w_lead_zero[r_idx] ? SEG_BLANK : w_seg_raw;
   assign w_an_hi  = DIGITS'(1) << r_idx;

   // Output register; polarity applied after decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg <= {7{ACTIVE_LOW}};
         r_dp  <= ACTIVE_LOW;
         r_an  <= {DIGITS{ACTIVE_LOW}};
      end else begin
         r_seg <= w_seg_hi ^ {7{ACTIVE_LOW}};
         r_dp  <= r_dpm[r_idx] ^ ACTIVE_LOW;
         r_an  <= w_an_hi ^ {DIGITS{ACTIVE_LOW}};
      end
   end

   assign bus.seg        = r_seg;
   assign bus.dp         = r_dp;
   assign bus.an         = r_an;
   assign bus.frame_done = r_frame;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Self-checking bench for sseg_mux_driver (DIGITS=4, PRESCALE=4, active-low).
module tb_sseg_mux_driver;

   localparam int D = 4;
   localparam int P = 4;

   localparam logic [6:0] HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   sseg_mux_driver_if #(.DIGITS(D)) bus ();

   sseg_mux_driver #(
      .DIGITS     (D),
      .PRESCALE   (P),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Pin-level pattern for digit i of a shadow word, from the display rules
   function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic h,
                                          input logic lz, input int i);
      logic [3:0]  nib;
      logic [15:0] upper;
      nib   = v[4*i +: 4];
      upper = v >> (4*i);
      if (lz && i != 0 && upper == 16'h0) return 7'h7F;
      if (!h && nib > 4'd9) return ~7'h40;
      return ~HEX[nib];
   endfunction

   // Model: k counts edges since reset; the digit shown after edge k+1 is (k/P)%D
   int          k;
   logic [15:0] m_v;
   logic        m_h, m_lz;
   logic [3:0]  m_dp;
   logic [6:0]  e_seg;
   logic        e_dp, e_fd, e_valid;
   logic [3:0]  e_an;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k       <= 0;
         m_v     <= '0;
         m_h     <= 1'b1;
         m_lz    <= 1'b0;
         m_dp    <= '0;
         e_valid <= 1'b0;
         e_fd    <= 1'b0;
      end else begin
         e_seg   <= exp_seg(m_v, m_h, m_lz, (k / P) % D);
         e_dp    <= ~m_dp[(k / P) % D];
         e_an    <= ~(4'b0001 << ((k / P) % D));
         e_fd    <= ((k + 1) % (D * P)) == 0;
         e_valid <= 1'b1;
         if (bus.load) begin
            m_v  <= bus.value;
            m_h  <= bus.hex_en;
            m_lz <= bus.lz_blank;
            m_dp <= bus.dp_mask;
         end
         k <= k + 1;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst && e_valid) begin
         chk("seg", {25'd0, bus.seg}, {25'd0, e_seg});
         chk("dp", {31'd0, bus.dp}, {31'd0, e_dp});
         chk("an", {28'd0, bus.an}, {28'd0, e_an});
         chk("frame_done", {31'd0, bus.frame_done}, {31'd0, e_fd});
         chk("an_onehot", $countones(~bus.an), 32'd1);
      end
   end

   task automatic do_load(input logic [15:0] v, input logic h, input logic lz,
                          input logic [3:0] dpm);
      @(negedge clk);
      bus.value    = v;
      bus.hex_en   = h;
      bus.lz_blank = lz;
      bus.dp_mask  = dpm;
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
   endtask

   // Wait for a fresh entry of anode pattern t (bounded)
   task automatic wait_an(input logic [3:0] t);
      int c = 0;
      @(negedge clk);
      while (bus.an == t && c < 40) begin @(negedge clk); c++; end
      while (bus.an != t && c < 40) begin @(negedge clk); c++; end
      chk("wait_an", {28'd0, bus.an}, {28'd0, t});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] an_before;
      int c;

      bus.load     = 1'b0;
      bus.value    = '0;
      bus.hex_en   = 1'b1;
      bus.lz_blank = 1'b0;
      bus.dp_mask  = '0;

      #2 rst = 1'b1;
      #10;
      chk("reset_seg", {25'd0, bus.seg}, 32'h7F);
      chk("reset_an", {28'd0, bus.an}, 32'hF);
      chk("reset_dp", {31'd0, bus.dp}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // First update shows digit 0 of zero
      @(posedge clk); #1;
      chk("first_an", {28'd0, bus.an}, 32'hE);
      chk("first_seg", {25'd0, bus.seg}, 32'h40);

      // Hex scan
      do_load(16'h1234, 1'b1, 1'b0, 4'b0000);
      wait_an(4'b1110); chk("hex_d0", {25'd0, bus.seg}, 32'h19);
      wait_an(4'b1101); chk("hex_d1", {25'd0, bus.seg}, 32'h30);
      wait_an(4'b1011); chk("hex_d2", {25'd0, bus.seg}, 32'h24);
      wait_an(4'b0111); chk("hex_d3", {25'd0, bus.seg}, 32'h79);

      // Frame period
      c = 0;
      while (!bus.frame_done && c < 40) begin @(negedge clk); c++; end
      chk("frame_seen", {31'd0, bus.frame_done}, 32'd1);
      c = 0;
      do begin @(negedge clk); c++; end while (!bus.frame_done && c < 40);
      chk("frame_period", c, 32'd16);

      // Asynchronous reset mid-scan
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_seg", {25'd0, bus.seg}, 32'h7F);
      chk("async_dp", {31'd0, bus.dp}, 32'd1);
      chk("async_an", {28'd0, bus.an}, 32'hF);
      chk("async_fd", {31'd0, bus.frame_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // BCD with invalid digit
      do_load(16'h00A5, 1'b0, 1'b0, 4'b0000);
      wait_an(4'b1101); chk("bcd_dash", {25'd0, bus.seg}, 32'h3F);
      wait_an(4'b1110); chk("bcd_5", {25'd0, bus.seg}, 32'h12);

      // Leading-zero blanking
      do_load(16'h0070, 1'b1, 1'b1, 4'b0000);
      wait_an(4'b0111); chk("lz_d3", {25'd0, bus.seg}, 32'h7F);
      wait_an(4'b1011); chk("lz_d2", {25'd0, bus.seg}, 32'h7F);
      wait_an(4'b1101); chk("lz_d1", {25'd0, bus.seg}, 32'h78);
      wait_an(4'b1110); chk("lz_d0", {25'd0, bus.seg}, 32'h40);
      do_load(16'h0000, 1'b1, 1'b1, 4'b0000);
      wait_an(4'b1101); chk("lz0_d1", {25'd0, bus.seg}, 32'h7F);
      wait_an(4'b1110); chk("lz0_d0", {25'd0, bus.seg}, 32'h40);

      // Decimal point on a blanked digit
      do_load(16'h0000, 1'b1, 1'b1, 4'b0100);
      wait_an(4'b1011);
      chk("dp_on", {31'd0, bus.dp}, 32'd0);
      chk("dp_blank", {25'd0, bus.seg}, 32'h7F);
      wait_an(4'b1101); chk("dp_off", {31'd0, bus.dp}, 32'd1);

      // Load coinciding with a tick
      do_load(16'h1111, 1'b1, 1'b0, 4'b0000);
      repeat (3) @(negedge clk);
      c = 0;
      while ((k % P) != P - 1 && c < 10) begin @(negedge clk); c++; end
      bus.value = 16'h2222;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
      an_before = bus.an;
      @(negedge clk);
      chk("tick_an_moved", {31'd0, bus.an != an_before}, 32'd1);
      chk("tick_new_seg", {25'd0, bus.seg}, 32'h24);

      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sseg_mux_driver.md
# sseg_mux_driver

Parametrised, time-multiplexed seven-segment display driver. It latches a packed multi-digit nibble word on a load strobe. It then scans one digit per refresh slot, driving shared segment lines and one anode line per digit. Hex/BCD decode, leading-zero blanking and per-digit decimal points are selectable at run time. It replaces the one-digit, switch-wired decoder/anode pair and sits between user logic and the board display pins.

## Interface
Parameters:
- DIGITS, 4: number of digits/anodes; legal range 1..8.
- PRESCALE, 100_000: clock cycles per digit slot; must be ≥1.
- ACTIVE_LOW, 1: 1 means seg, dp and an are driven active-low at the pins; 0 means active-high.

Ports (reset is asynchronous, active-high; single clock domain):
- clk, input, 1: system clock; all state is updated on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- value, input, 4*DIGITS: packed digits; nibble i drives digit i, and digit 0 is least significant (rightmost).
- load, input, 1: single-cycle strobe; captures value, hex_en, lz_blank and dp_mask.
- hex_en, input, 1: 1 decodes nibbles as 0-F; 0 decodes as BCD, with A-F shown as a dash (segment g only).
- lz_blank, input, 1: 1 blanks leading zeros.
- dp_mask, input, DIGITS: bit i lights the decimal point of digit i.
- seg, output, 7: seg[0]=a … seg[6]=g.
- dp, output, 1: decimal point.
- an, output, DIGITS: one-hot digit enable at the active level.
- frame_done, output, 1: one-cycle pulse when the scan wraps from the last digit back to digit 0.

## Operation
- **Shadow register.** When load=1, the inputs value, hex_en, lz_blank and dp_mask are captured into a shadow register on that rising edge. The scan reads only the shadow register; live inputs are ignored outside a load.
- **Prescaler.** Counts 0..PRESCALE-1. Reaching the terminal count generates a tick and wraps the prescaler to 0. With PRESCALE=1 there is a tick every cycle.
- **Digit index.** Advances on each tick, 0→1→…→DIGITS-1→0. The tick taken at index DIGITS-1 asserts frame_done for exactly that cycle.
- **Output register.** Every cycle it registers seg, dp and an, decoded from the current index and the shadow register.
- **Decode for digit i:**
  - Leading-zero blanking: if lz_blank=1 and nibbles DIGITS-1..i are all 0 and i≠0, the segments are blank. Digit 0 is never blanked.
  - dp = dp_mask[i], independent of blanking.
  - The anode of digit i is active and all other anodes are inactive.
- **Polarity.** All output polarity inversion is applied after decode, controlled by ACTIVE_LOW.
- **Simultaneous load and tick.** Both take effect on the same edge. The next output update uses the new shadow register and the new index.
- **Reset.** Asserting rst mid-scan immediately forces all state and outputs to their reset values, without waiting for a clock edge.

## Timing
Reset values:
- prescaler = 0, index = 0.
- shadow: value = 0, hex_en = 1, lz_blank = 0, dp_mask = 0.
- frame_done = 0.
- seg, dp and an are all inactive. For ACTIVE_LOW=1 this is seg=7'h7F, dp=1, an='1.

Cycle-level behaviour:
- **First update.** The first output update is on the first rising edge after rst deasserts. It shows digit 0 of the shadow value 0, i.e. seg='0'.
- **Load latency.** With load sampled at edge n, the shadow register is valid after edge n; the pins reflect it after edge n+1 (within the currently active digit).
- **Digit dwell.** Each digit is displayed for exactly PRESCALE cycles.
- **Frame period.** One full frame is DIGITS*PRESCALE cycles, and frame_done pulses once per frame.
- **Anode glitch-freedom.** Exactly one anode is active in every cycle after the first update. No two anodes are ever active in the same cycle.

## Structure
- **Package sseg_pkg:**
  - Constants SEG_BLANK (7'h00, active-high), SEG_DASH (7'h40).
  - The 16-entry hex segment table.
  - A typedef for the 7-bit segment vector.
- **Sub-module sseg_encoder:** combinational; maps a nibble plus hex_en to an active-high segment vector. It is instantiated once, after the index mux.
- **Top level** holds the prescaler, index counter, shadow register, blanking logic and output register.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4 and ACTIVE_LOW=1.
- **Reset.** Assert rst mid-scan with no clock edge. Required: seg=7'h7F, dp=1, an=4'hF and frame_done=0 immediately.
- **Hex scan.** Load value=16'h1234, hex_en=1. Required: an steps 1110→1101→1011→0111 every 4 cycles, with seg 7'h19 ('4'), 7'h30 ('3'), 7'h24 ('2'), 7'h79 ('1'). frame_done pulses every 16 cycles.
- **BCD invalid digit.** Load 16'h00A5 with hex_en=0. Required: digit 1 shows 7'h3F (dash) and digit 0 shows 7'h12 ('5').
- **Leading-zero blanking.** Load 16'h0070 with lz_blank=1. Required: digits 3 and 2 show 7'h7F, digit 1 shows 7'h78 ('7') and digit 0 shows 7'h40 ('0'). Loading 16'h0000 shows only digit 0 lit as '0'.
- **Decimal point.** Set dp_mask=4'b0100 with lz_blank=1 and value=0. Required: dp=0 only while an=1011, even though that digit's segments are blank.
- **Load on tick.** Assert load on the same cycle as a tick, changing value from 16'h1111 to 16'h2222. Required: the very next digit displayed shows '2' (7'h24), and no stale '1' appears.
